// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator motion controller: state encoding,
// floor counts, request-code constants and small floor-mask helpers.
package elevator_pkg;

    localparam int NUM_FLOORS   = 4;
    localparam int FLOOR_W      = 2;
    localparam int FLOOR_CODE_W = 3;

    // Request code meaning "no request"; codes at or above it are never floors.
    localparam logic [FLOOR_CODE_W-1:0] FLOOR_NONE = 3'b100;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    // Single-bit mask selecting floor f.
    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i == int'(f));
        end
        return m;
    endfunction

    // Mask of every floor strictly above f.
    function automatic logic [NUM_FLOORS-1:0] floors_above(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i > int'(f));
        end
        return m;
    endfunction

    // Mask of every floor strictly below f.
    function automatic logic [NUM_FLOORS-1:0] floors_below(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i < int'(f));
        end
        return m;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter used for both travel and door dwell timing.
// done is high during the last counted cycle, so a load of N followed by
// N enabled cycles ends with done asserted in the Nth cycle.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             done
);

    logic [WIDTH-1:0] count_reg;

    // Load has priority over counting; counting stops at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && (count_reg != '0)) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign done = enable && (count_reg == WIDTH'(1));

endmodule

// File: rtl/elevator_motion_controller.sv
// Four-floor elevator motion controller: latches floor requests, moves the
// car one floor per TRAVEL_CYCLES, dwells DOOR_CYCLES with the door open at
// each requested floor and keeps its travel direction while work remains ahead.
// Optional feature macro: DOOR_HOLD_EN adds a door_hold input that keeps the
// door open (dwell timer held at restart) for as long as it is high.
module elevator_motion_controller
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 50,
    parameter int DOOR_CYCLES   = 100
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef DOOR_HOLD_EN
    input  logic                    door_hold,
`endif
    input  logic [FLOOR_CODE_W-1:0] floor_destiny,
    output logic [FLOOR_W-1:0]      current_floor,
    output logic [NUM_FLOORS-1:0]   floor_onehot,
    output logic                    motor_up,
    output logic                    motor_down,
    output logic                    door_open,
    output logic [NUM_FLOORS-1:0]   pending,
    output logic                    busy
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);

    state_t                state_reg, state_next;
    logic [FLOOR_W-1:0]    floor_reg, floor_next;
    logic [NUM_FLOORS-1:0] pending_reg, pending_next;
    logic                  dir_up_reg, dir_up_next;

    logic                  hold;
    logic                  timer_load, timer_door, timer_enable, timer_done;
    logic [TIMER_W-1:0]    timer_value;

    logic [NUM_FLOORS-1:0] req_mask, set_mask, clr_mask;
    logic [FLOOR_W-1:0]    step_floor, dec_floor;
    logic                  any_above, any_below, pick_up, pick_down;

`ifdef DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    // Travel or dwell timer; the door timer freezes (reloads) while held.
    assign timer_enable = (state_reg == MOVE_UP) || (state_reg == MOVE_DOWN) ||
                          ((state_reg == DOOR_OPEN) && !hold);
    assign timer_value  = timer_door ? TIMER_W'(DOOR_CYCLES) : TIMER_W'(TRAVEL_CYCLES);

    cycle_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timer_load),
        .load_value(timer_value),
        .enable    (timer_enable),
        .done      (timer_done)
    );

    // Next-state, request bookkeeping and timer control.
    always_comb begin
        state_next  = state_reg;
        floor_next  = floor_reg;
        dir_up_next = dir_up_reg;
        timer_load  = 1'b0;
        timer_door  = 1'b0;
        clr_mask    = '0;

        req_mask = (floor_destiny < FLOOR_NONE) ? floor_mask(floor_destiny[FLOOR_W-1:0]) : '0;
        set_mask = req_mask;

        // Floor the car reaches at the end of the current step.
        step_floor = (state_reg == MOVE_UP) ? floor_reg + 2'd1 : floor_reg - 2'd1;

        // Direction choice after a stop or a non-stopping arrival: keep going
        // while work lies ahead, otherwise reverse, otherwise go idle.
        dec_floor = (state_reg == DOOR_OPEN) ? floor_reg : step_floor;
        any_above = |(pending_reg & floors_above(dec_floor));
        any_below = |(pending_reg & floors_below(dec_floor));
        pick_up   = any_above && (dir_up_reg || !any_below);
        pick_down = any_below && !pick_up;

        case (state_reg)
            IDLE: begin
                if (pending_reg[floor_reg] || req_mask[floor_reg]) begin
                    state_next  = DOOR_OPEN;
                    clr_mask    = floor_mask(floor_reg);
                    dir_up_next = 1'b1;
                    timer_load  = 1'b1;
                    timer_door  = 1'b1;
                end else if (|(pending_reg & floors_above(floor_reg))) begin
                    state_next  = MOVE_UP;
                    dir_up_next = 1'b1;
                    timer_load  = 1'b1;
                end else if (|(pending_reg & floors_below(floor_reg))) begin
                    state_next  = MOVE_DOWN;
                    dir_up_next = 1'b0;
                    timer_load  = 1'b1;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (timer_done) begin
                    floor_next = step_floor;
                    timer_load = 1'b1;
                    if (pending_reg[step_floor] || req_mask[step_floor]) begin
                        state_next = DOOR_OPEN;
                        clr_mask   = floor_mask(step_floor);
                        timer_door = 1'b1;
                    end else if (pick_up) begin
                        state_next  = MOVE_UP;
                        dir_up_next = 1'b1;
                    end else if (pick_down) begin
                        state_next  = MOVE_DOWN;
                        dir_up_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                        timer_load = 1'b0;
                    end
                end
            end
            DOOR_OPEN: begin
                // A call for the floor we are already serving is simply absorbed.
                set_mask = req_mask & ~floor_mask(floor_reg);
                if (hold) begin
                    timer_load = 1'b1;
                    timer_door = 1'b1;
                end else if (timer_done) begin
                    if (pick_up) begin
                        state_next  = MOVE_UP;
                        dir_up_next = 1'b1;
                        timer_load  = 1'b1;
                    end else if (pick_down) begin
                        state_next  = MOVE_DOWN;
                        dir_up_next = 1'b0;
                        timer_load  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A clear for the floor being served wins over a same-cycle request.
        pending_next = (pending_reg | set_mask) & ~clr_mask;
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            floor_reg   <= '0;
            pending_reg <= '0;
            dir_up_reg  <= 1'b1;
        end else begin
            state_reg   <= state_next;
            floor_reg   <= floor_next;
            pending_reg <= pending_next;
            dir_up_reg  <= dir_up_next;
        end
    end

    // Indicator LEDs decoded straight from the registered floor.
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_onehot
        assign floor_onehot[gi] = (floor_reg == FLOOR_W'(gi));
    end

    assign current_floor = floor_reg;
    assign pending       = pending_reg;
    assign motor_up      = (state_reg == MOVE_UP);
    assign motor_down    = (state_reg == MOVE_DOWN);
    assign door_open     = (state_reg == DOOR_OPEN);
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_elevator_motion_controller.sv
// Directed bench for elevator_motion_controller (TRAVEL_CYCLES=4, DOOR_CYCLES=3):
// a per-cycle vector table plus hand sequences for multi-cycle behaviour.
module tb_elevator_motion_controller;

    localparam int TC = 4;
    localparam int DC = 3;

    localparam int S_IDLE = 0;
    localparam int S_UP   = 1;
    localparam int S_DOWN = 2;
    localparam int S_DOOR = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] floor_destiny = 3'd4;
    logic [1:0] current_floor;
    logic [3:0] floor_onehot;
    logic       motor_up, motor_down, door_open, busy;
    logic [3:0] pending;
`ifdef DOOR_HOLD_EN
    logic       door_hold = 1'b0;
`endif

    elevator_motion_controller #(
        .TRAVEL_CYCLES(TC),
        .DOOR_CYCLES  (DC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef DOOR_HOLD_EN
        .door_hold    (door_hold),
`endif
        .floor_destiny(floor_destiny),
        .current_floor(current_floor),
        .floor_onehot (floor_onehot),
        .motor_up     (motor_up),
        .motor_down   (motor_down),
        .door_open    (door_open),
        .pending      (pending),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [1:0] fl;
        int         st;
        logic [3:0] pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input int req, input int fl, input int st,
                                input logic [3:0] pend);
        vec_t v;
        v.rst  = r;
        v.req  = 3'(req);
        v.fl   = 2'(fl);
        v.st   = st;
        v.pend = pend;
        return v;
    endfunction

    task automatic add(input int n, input logic r, input int req, input int fl, input int st,
                       input logic [3:0] pend);
        for (int k = 0; k < n; k++) vecs.push_back(mk(r, req, fl, st, pend));
    endtask

    // Drive one cycle of inputs, then compare every output after the edge.
    task automatic apply_check(input vec_t x, input int idx);
        logic       e_up, e_dn, e_door, e_busy;
        logic [3:0] e_oh;
        @(negedge clk);
        rst_n = x.rst;
        floor_destiny = x.req;
        @(posedge clk);
        #1;
        e_up   = (x.st == S_UP);
        e_dn   = (x.st == S_DOWN);
        e_door = (x.st == S_DOOR);
        e_busy = (x.st != S_IDLE);
        e_oh   = 4'b0001 << x.fl;
        checks++;
        if (current_floor !== x.fl || floor_onehot !== e_oh || motor_up !== e_up ||
            motor_down !== e_dn || door_open !== e_door || pending !== x.pend ||
            busy !== e_busy || (int'(motor_up) + int'(motor_down) + int'(door_open)) > 1) begin
            errors++;
            $display("FAIL vec[%0d]: got floor=%0d onehot=%b up=%b dn=%b door=%b pend=%b busy=%b, want floor=%0d onehot=%b up=%b dn=%b door=%b pend=%b busy=%b",
                     idx, current_floor, floor_onehot, motor_up, motor_down, door_open, pending, busy,
                     x.fl, e_oh, e_up, e_dn, e_door, x.pend, e_busy);
        end else begin
            $display("vec[%0d] ok: rst_n=%b req=%0d floor=%0d state=%0d pend=%b",
                     idx, x.rst, x.req, current_floor, x.st, pending);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end else begin
            $display("%s ok: %b", name, got);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end else begin
            $display("%s ok: %0d", name, got);
        end
    endtask

    initial begin
        int  down_cnt;
        bit  door_seen;

        // Reset and idle with no requests.
        add(1,  1'b0, 4, 0, S_IDLE, 4'b0000);
        add(20, 1'b1, 4, 0, S_IDLE, 4'b0000);
        // Floor 0 -> 2: two steps of 4 cycles, 3-cycle dwell, back to idle.
        add(1, 1'b1, 2, 0, S_IDLE, 4'b0100);
        add(4, 1'b1, 4, 0, S_UP,   4'b0100);
        add(4, 1'b1, 4, 1, S_UP,   4'b0100);
        add(3, 1'b1, 4, 2, S_DOOR, 4'b0000);
        add(1, 1'b1, 4, 2, S_IDLE, 4'b0000);
        // Call for the current floor; repeats during dwell do not extend it.
        add(3, 1'b1, 2, 2, S_DOOR, 4'b0000);
        add(1, 1'b1, 4, 2, S_IDLE, 4'b0000);
        // Invalid codes are ignored.
        add(1, 1'b1, 5, 2, S_IDLE, 4'b0000);
        add(1, 1'b1, 6, 2, S_IDLE, 4'b0000);
        add(1, 1'b1, 7, 2, S_IDLE, 4'b0000);
        // Reset, call 3, pick up 1 en route, call 0 en route, reverse at 3.
        add(1, 1'b0, 4, 0, S_IDLE, 4'b0000);
        add(1, 1'b1, 3, 0, S_IDLE, 4'b1000);
        add(1, 1'b1, 4, 0, S_UP,   4'b1000);
        add(1, 1'b1, 1, 0, S_UP,   4'b1010);
        add(1, 1'b1, 5, 0, S_UP,   4'b1010);
        add(1, 1'b1, 6, 0, S_UP,   4'b1010);
        add(1, 1'b1, 7, 1, S_DOOR, 4'b1000);
        add(2, 1'b1, 4, 1, S_DOOR, 4'b1000);
        add(1, 1'b1, 4, 1, S_UP,   4'b1000);
        add(1, 1'b1, 0, 1, S_UP,   4'b1001);
        add(2, 1'b1, 4, 1, S_UP,   4'b1001);
        add(4, 1'b1, 4, 2, S_UP,   4'b1001);
        add(3, 1'b1, 4, 3, S_DOOR, 4'b0001);
        add(4, 1'b1, 4, 3, S_DOWN, 4'b0001);
        add(4, 1'b1, 4, 2, S_DOWN, 4'b0001);
        add(4, 1'b1, 4, 1, S_DOWN, 4'b0001);
        add(3, 1'b1, 4, 0, S_DOOR, 4'b0000);
        add(1, 1'b1, 4, 0, S_IDLE, 4'b0000);
        // Reset mid-move at floor 1 discards everything, including a same-cycle call.
        add(1, 1'b1, 3, 0, S_IDLE, 4'b1000);
        add(4, 1'b1, 4, 0, S_UP,   4'b1000);
        add(1, 1'b1, 4, 1, S_UP,   4'b1000);
        add(1, 1'b0, 2, 0, S_IDLE, 4'b0000);
        add(1, 1'b1, 4, 0, S_IDLE, 4'b0000);
        // Call made in the arrival cycle stops the car; clear beats set at floor 2.
        add(1, 1'b1, 2, 0, S_IDLE, 4'b0100);
        add(4, 1'b1, 4, 0, S_UP,   4'b0100);
        add(1, 1'b1, 1, 1, S_DOOR, 4'b0100);
        add(2, 1'b1, 4, 1, S_DOOR, 4'b0100);
        add(4, 1'b1, 4, 1, S_UP,   4'b0100);
        add(1, 1'b1, 2, 2, S_DOOR, 4'b0000);
        add(2, 1'b1, 4, 2, S_DOOR, 4'b0000);
        add(1, 1'b1, 4, 2, S_IDLE, 4'b0000);

        foreach (vecs[i]) apply_check(vecs[i], i);

        // From floor 2 call 0: motor_down for exactly 2*TC cycles, then the door.
        @(negedge clk);
        floor_destiny = 3'd0;
        @(negedge clk);
        floor_destiny = 3'd4;
        down_cnt  = 0;
        door_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (door_open) begin
                door_seen = 1'b1;
                break;
            end
            if (motor_down) down_cnt++;
        end
        check_bit("down_door_reached", door_seen, 1'b1);
        check_int("down_motor_cycles", down_cnt, 2 * TC);
        check_int("down_arrival_floor", int'(current_floor), 0);
        repeat (DC) @(posedge clk);
        #1;
        check_bit("down_back_idle_busy", busy, 1'b0);

`ifdef DOOR_HOLD_EN
        // Door held for 10 cycles stays open, then closes DC cycles after release.
        @(negedge clk);
        floor_destiny = 3'd0;
        @(negedge clk);
        floor_destiny = 3'd4;
        door_hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check_bit("hold_door_open", door_open, 1'b1);
        end
        @(negedge clk);
        door_hold = 1'b0;
        for (int k = 0; k < DC; k++) begin
            @(posedge clk);
            #1;
            check_bit("release_door_open", door_open, (k < DC - 1) ? 1'b1 : 1'b0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
